aes_output_buffer: RTL and testbench

//   Output-side counterpart of the AES input buffer. Captures the 128-bit result block from the
//   AES core on its done pulse and streams it out as WORDS x DW-bit words over valid/ready.

---
 rtl/aes_pkg.sv | 12 +
 rtl/aes_word_sel.sv | 16 +
 rtl/aes_output_buffer.sv | 139 +++++++++++++
 tb/tb_aes_output_buffer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath constants and the output-buffer state type.
package aes_pkg;

    localparam int AES_BLK_W  = 128;
    localparam int AES_WORD_W = 32;

    typedef enum logic {
        OB_IDLE = 1'b0,
        OB_SEND = 1'b1
    } aes_ob_state_t;

endpackage : aes_pkg

// File: rtl/aes_word_sel.sv
// Combinational word selector: returns word i_idx of a DW*WORDS-bit block, word 0 in the LSBs.
module aes_word_sel #(
    parameter int DW    = 32,
    parameter int WORDS = 4,
    parameter int IDXW  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic [DW*WORDS-1:0] i_blk,
    input  logic [IDXW-1:0]     i_idx,
    output logic [DW-1:0]       o_word
);

    always_comb begin
        o_word = i_blk[i_idx*DW +: DW];
    end

endmodule : aes_word_sel

// File: rtl/aes_output_buffer.sv
// Streams a captured AES result block out as WORDS x DW-bit words over valid/ready.
// Define AES_OUT_DBLBUF_EN to add a one-deep pending block so a result arriving mid-stream is kept.
module aes_output_buffer
    import aes_pkg::*;
#(
    parameter int DW    = AES_WORD_W,
    parameter int WORDS = AES_BLK_W / AES_WORD_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                done_i,
    input  logic [DW*WORDS-1:0] text_i,
    output logic [DW-1:0]       data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                last_o,
    output logic                busy_o,
    output logic                ovf_o
);

    localparam int              BLK_W    = DW * WORDS;
    localparam int              IDXW     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    aes_ob_state_t      r_state;
    logic [IDXW-1:0]    r_idx;
    logic [BLK_W-1:0]   r_blk;
    logic               r_ovf;
    logic [DW-1:0]      w_word;
    logic               w_send;
    logic               w_beat;
    logic               w_final;

    assign w_send  = (r_state == OB_SEND);
    assign w_beat  = w_send & ready_i;
    assign w_final = w_beat & (r_idx == LAST_IDX);

    aes_word_sel #(
        .DW    (DW),
        .WORDS (WORDS),
        .IDXW  (IDXW)
    ) u_word_sel (
        .i_blk  (r_blk),
        .i_idx  (r_idx),
        .o_word (w_word)
    );

    // Gated so data_o reads zero whenever no word is on offer, including out of reset.
    assign data_o  = w_send ? w_word : '0;
    assign valid_o = w_send;
    assign last_o  = w_send & (r_idx == LAST_IDX);
    assign ovf_o   = r_ovf;

`ifdef AES_OUT_DBLBUF_EN
    logic [BLK_W-1:0]   r_pend_blk;
    logic               r_pend;

    assign busy_o = r_pend & ~w_final;

    // NOTE: reset is sampled on the clock edge (synchronous); all state uses non-blocking <=.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= OB_IDLE;
            r_idx      <= '0;
            r_blk      <= '0;
            r_ovf      <= 1'b0;
            r_pend_blk <= '0;
            r_pend     <= 1'b0;
        end else if (!w_send) begin
            if (done_i) begin
                r_state <= OB_SEND;
                r_idx   <= '0;
                r_blk   <= text_i;
            end
        end else if (w_final) begin
            r_idx <= '0;
            if (r_pend) begin
                // Pending block goes live; a simultaneous arrival refills the pending slot.
                r_blk <= r_pend_blk;
                if (done_i) begin
                    r_pend_blk <= text_i;
                end else begin
                    r_pend <= 1'b0;
                end
            end else if (done_i) begin
                r_blk <= text_i;
            end else begin
                r_state <= OB_IDLE;
            end
        end else begin
            if (w_beat) begin
                r_idx <= r_idx + 1'b1;
            end
            if (done_i) begin
                if (r_pend) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_pend_blk <= text_i;
                    r_pend     <= 1'b1;
                end
            end
        end
    end
`else
    assign busy_o = w_send & ~w_final;

    // NOTE: reset is sampled on the clock edge (synchronous); all state uses non-blocking <=.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= OB_IDLE;
            r_idx   <= '0;
            r_blk   <= '0;
            r_ovf   <= 1'b0;
        end else if (!w_send) begin
            if (done_i) begin
                r_state <= OB_SEND;
                r_idx   <= '0;
                r_blk   <= text_i;
            end
        end else if (w_final) begin
            // A result landing on the final beat is chained straight in with no idle gap.
            r_idx <= '0;
            if (done_i) begin
                r_blk <= text_i;
            end else begin
                r_state <= OB_IDLE;
            end
        end else begin
            if (w_beat) begin
                r_idx <= r_idx + 1'b1;
            end
            if (done_i) begin
                r_ovf <= 1'b1;
            end
        end
    end
`endif

endmodule : aes_output_buffer

// File: tb/tb_aes_output_buffer.sv
// Directed self-checking bench for aes_output_buffer (default build; DBLBUF scenario when AES_OUT_DBLBUF_EN is defined).
module tb_aes_output_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         done_i;
    logic [127:0] text_i;
    logic [31:0]  data_o;
    logic         valid_o;
    logic         ready_i;
    logic         last_o;
    logic         busy_o;
    logic         ovf_o;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] BLK_B = 128'hfedcba98_76543210_0f1e2d3c_4b5a6978;
    localparam logic [127:0] BLK_C = 128'hdeadbeef_cafef00d_01234567_89abcdef;

    logic [31:0] words_a [4] = '{32'hccddeeff, 32'h8899aabb, 32'h44556677, 32'h00112233};
    logic [31:0] words_b [4] = '{32'h4b5a6978, 32'h0f1e2d3c, 32'h76543210, 32'hfedcba98};

    aes_output_buffer dut (
        .clk     (clk),
        .rst     (rst),
        .done_i  (done_i),
        .text_i  (text_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .last_o  (last_o),
        .busy_o  (busy_o),
        .ovf_o   (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply this cycle's inputs half a period before the sampling edge, then let outputs settle.
    task automatic drive(input logic d, input logic [127:0] t, input logic r);
        @(negedge clk);
        done_i  = d;
        text_i  = t;
        ready_i = r;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b0;
        done_i  = 1'b0;
        text_i  = '0;
        ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int beats;
        logic [6:0] rdy_pat;
        rst     = 1'b0;
        done_i  = 1'b0;
        text_i  = '0;
        ready_i = 1'b0;
        do_reset();

        // Reset state
        check("rst_valid", valid_o, 0);
        check("rst_data",  data_o,  0);
        check("rst_last",  last_o,  0);
        check("rst_ovf",   ovf_o,   0);
        check("rst_busy",  busy_o,  0);

        // 1: single block, sink always ready
        drive(1'b1, BLK_A, 1'b1);
        check("t1_idle_valid", valid_o, 0);
        check("t1_idle_busy",  busy_o,  0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, '0, 1'b1);
            check($sformatf("t1_valid%0d", k), valid_o, 1);
            check($sformatf("t1_data%0d", k),  data_o,  words_a[k]);
            check($sformatf("t1_last%0d", k),  last_o,  (k == 3));
        end
        drive(1'b0, '0, 1'b1);
        check("t1_done_valid", valid_o, 0);

        // 2: back-pressure, ready pattern 1,0,0,1,0,1,1
        rdy_pat = 7'b1101001;
        drive(1'b1, BLK_A, 1'b0);
        beats = 0;
        for (int k = 0; k < 7; k++) begin
            drive(1'b0, '0, rdy_pat[k]);
            check($sformatf("t2_valid%0d", k), valid_o, 1);
            check($sformatf("t2_data%0d", k),  data_o,  words_a[beats]);
            check($sformatf("t2_last%0d", k),  last_o,  (beats == 3));
            if (rdy_pat[k]) beats++;
        end
        check("t2_beats", beats, 4);
        drive(1'b0, '0, 1'b1);
        check("t2_done_valid", valid_o, 0);

`ifdef AES_OUT_DBLBUF_EN
        // 5: two arrivals mid-stream: first queued, second dropped
        drive(1'b1, BLK_A, 1'b1);
        drive(1'b1, BLK_B, 1'b1);
        check("t5_data0", data_o, words_a[0]);
        check("t5_busy0", busy_o, 0);
        drive(1'b1, BLK_C, 1'b1);
        check("t5_data1", data_o, words_a[1]);
        check("t5_busy1", busy_o, 1);
        check("t5_ovf1",  ovf_o,  0);
        drive(1'b0, '0, 1'b1);
        check("t5_data2", data_o, words_a[2]);
        check("t5_ovf2",  ovf_o,  1);
        drive(1'b0, '0, 1'b1);
        check("t5_data3", data_o, words_a[3]);
        check("t5_last3", last_o, 1);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, '0, 1'b1);
            check($sformatf("t5_b_valid%0d", k), valid_o, 1);
            check($sformatf("t5_b_data%0d", k),  data_o,  words_b[k]);
        end
        drive(1'b0, '0, 1'b1);
        check("t5_end_valid", valid_o, 0);
        check("t5_end_ovf",   ovf_o,   1);
`else
        // 3: arrival during beat 2 is dropped, stream unaffected
        drive(1'b1, BLK_A, 1'b1);
        drive(1'b0, '0, 1'b1);
        check("t3_data0", data_o, words_a[0]);
        drive(1'b1, BLK_B, 1'b1);
        check("t3_data1", data_o, words_a[1]);
        check("t3_busy1", busy_o, 1);
        check("t3_ovf1",  ovf_o,  0);
        drive(1'b0, '0, 1'b1);
        check("t3_data2", data_o, words_a[2]);
        check("t3_ovf2",  ovf_o,  1);
        drive(1'b0, '0, 1'b1);
        check("t3_data3", data_o, words_a[3]);
        check("t3_last3", last_o, 1);
        drive(1'b0, '0, 1'b1);
        check("t3_end_valid", valid_o, 0);
        check("t3_end_ovf",   ovf_o,   1);
`endif

        // 4: arrival on the final beat chains the next block with no gap
        do_reset();
        check("t4_rst_ovf", ovf_o, 0);
        drive(1'b1, BLK_A, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, 1'b1);
            check($sformatf("t4_a_data%0d", k), data_o, words_a[k]);
        end
        drive(1'b1, BLK_B, 1'b1);
        check("t4_a_data3", data_o, words_a[3]);
        check("t4_a_last3", last_o, 1);
        check("t4_busy_final", busy_o, 0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, '0, 1'b1);
            check($sformatf("t4_b_valid%0d", k), valid_o, 1);
            check($sformatf("t4_b_data%0d", k),  data_o,  words_b[k]);
            check($sformatf("t4_b_last%0d", k),  last_o,  (k == 3));
        end
        check("t4_ovf", ovf_o, 0);
        drive(1'b0, '0, 1'b1);
        check("t4_end_valid", valid_o, 0);

        // 6: reset mid-stream discards the block; a following done restarts cleanly
        drive(1'b1, BLK_A, 1'b1);
        drive(1'b0, '0, 1'b1);
        check("t6_data0", data_o, words_a[0]);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("t6_rst_valid", valid_o, 0);
        check("t6_rst_ovf",   ovf_o,   0);
        check("t6_rst_busy",  busy_o,  0);
        check("t6_rst_data",  data_o,  0);
        rst = 1'b1;
        drive(1'b1, BLK_B, 1'b1);
        check("t6_idle_valid", valid_o, 0);
        drive(1'b0, '0, 1'b1);
        check("t6_restart_valid", valid_o, 1);
        check("t6_restart_data",  data_o,  words_b[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_aes_output_buffer
